// File: rtl/irq_ctrl_wb8.sv
// 8-bit Wishbone interrupt controller: per-source edge/level capture, mask and priority ID.
// Optional macro IRQ_CTRL_SYNC_EN adds a 2-flop synchronizer on every I_irq input.
module irq_ctrl_wb8 #(
    parameter int NUM_IRQ = 8
) (
    input  logic               CLK_I,
    input  logic               RST_I,
    input  logic [1:0]         ADR_I,
    input  logic [7:0]         DAT_I,
    output logic [7:0]         DAT_O,
    input  logic               STB_I,
    input  logic               WE_I,
    output logic               ACK_O,
    input  logic [NUM_IRQ-1:0] I_irq,
    output logic               O_interrupt
);

    localparam logic [1:0] ADR_PEND = 2'd0;
    localparam logic [1:0] ADR_EN   = 2'd1;
    localparam logic [1:0] ADR_MODE = 2'd2;
    localparam logic [1:0] ADR_ID   = 2'd3;

    logic [NUM_IRQ-1:0] cur, prev, pending, enable, mode;
    logic [NUM_IRQ-1:0] wdat, rise, w1c, pend_nxt, enable_nxt, mode_nxt, active;
    logic               acc, wr;
    logic [7:0]         id_val, rd_val;

    function automatic logic [7:0] widen(input logic [NUM_IRQ-1:0] v);
        logic [7:0] r;
        r = '0;
        r[NUM_IRQ-1:0] = v;
        return r;
    endfunction

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync_p0, sync_p1;

    // Synchronizer stages p0 -> p1
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= I_irq;
            sync_p1 <= sync_p0;
        end
    end

    assign cur = sync_p1;
`else
    assign cur = I_irq;
`endif

    always_comb begin
        acc        = STB_I & ~ACK_O;
        wr         = acc & WE_I;
        wdat       = DAT_I[NUM_IRQ-1:0];
        rise       = cur & ~prev;
        w1c        = (wr && ADR_I == ADR_PEND) ? wdat : '0;
        enable_nxt = (wr && ADR_I == ADR_EN)   ? wdat : enable;
        mode_nxt   = (wr && ADR_I == ADR_MODE) ? wdat : mode;
        active     = pending & enable;

        // A bit leaving level mode restarts empty; only a fresh edge may set it.
        pend_nxt = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (mode[i])
                pend_nxt[i] = (pending[i] & ~w1c[i]) | rise[i];
            else if (mode_nxt[i])
                pend_nxt[i] = rise[i];
            else
                pend_nxt[i] = cur[i];
        end

        id_val = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (active[i])
                id_val = {1'b1, 4'b0000, 3'(i)};
        end

        rd_val = '0;
        case (ADR_I)
            ADR_PEND: rd_val = widen(pending);
            ADR_EN:   rd_val = widen(enable);
            ADR_MODE: rd_val = widen(mode);
            ADR_ID:   rd_val = id_val;
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            pending     <= '0;
            enable      <= '0;
            mode        <= '0;
            prev        <= '1;
            DAT_O       <= '0;
            ACK_O       <= 1'b0;
            O_interrupt <= 1'b0;
        end else begin
            ACK_O       <= STB_I & ~ACK_O;
            prev        <= cur;
            pending     <= pend_nxt;
            enable      <= enable_nxt;
            mode        <= mode_nxt;
            O_interrupt <= |active;
            if (acc)
                DAT_O <= rd_val;
        end
    end

endmodule

// File: tb/tb_irq_ctrl_wb8.sv
// Scoreboard bench for irq_ctrl_wb8: bus accesses queue expected read data, a monitor checks on ACK_O.
module tb_irq_ctrl_wb8;
    localparam int NUM_IRQ = 8;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic               CLK_I;
    logic               RST_I;
    logic [1:0]         ADR_I;
    logic [7:0]         DAT_I;
    logic [7:0]         DAT_O;
    logic               STB_I;
    logic               WE_I;
    logic               ACK_O;
    logic [NUM_IRQ-1:0] I_irq;
    logic               O_interrupt;

    irq_ctrl_wb8 #(.NUM_IRQ(NUM_IRQ)) dut (
        .CLK_I       (CLK_I),
        .RST_I       (RST_I),
        .ADR_I       (ADR_I),
        .DAT_I       (DAT_I),
        .DAT_O       (DAT_O),
        .STB_I       (STB_I),
        .WE_I        (WE_I),
        .ACK_O       (ACK_O),
        .I_irq       (I_irq),
        .O_interrupt (O_interrupt)
    );

    initial CLK_I = 1'b0;
    always #5 CLK_I = ~CLK_I;

    typedef struct {
        bit         rd;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic bus(input bit we, input logic [1:0] adr, input logic [7:0] dat,
                       input logic [7:0] exp, input string name);
        exp_t e;
        e.rd   = !we;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
        STB_I = 1'b1;
        WE_I  = we;
        ADR_I = adr;
        DAT_I = dat;
        tick();
        STB_I = 1'b0;
        WE_I  = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [1:0] adr, input logic [7:0] dat);
        bus(1'b1, adr, dat, 8'h00, "write");
    endtask

    task automatic rd(input logic [1:0] adr, input logic [7:0] exp, input string name);
        bus(1'b0, adr, 8'h00, exp, name);
    endtask

    always @(negedge CLK_I) begin
        if (!RST_I && ACK_O === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_ack: got ACK_O=1 with DAT_O=0x%02h, expected no ack", DAT_O);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.rd)
                    check(mon_e.name, DAT_O, mon_e.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RST_I = 1'b1;
        STB_I = 1'b0;
        WE_I  = 1'b0;
        ADR_I = 2'd0;
        DAT_I = 8'h00;
        I_irq = 8'h01;
        repeat (3) tick();
        RST_I = 1'b0;

        // Reset state with source 0 held high
        check("rst_ack", {7'b0, ACK_O}, 8'h00);
        check("rst_dat", DAT_O, 8'h00);
        check("rst_irq", {7'b0, O_interrupt}, 8'h00);
        rd(2'd1, 8'h00, "rst_enable");
        rd(2'd2, 8'h00, "rst_mode");
        rd(2'd3, 8'h00, "rst_id");
        wr(2'd2, 8'h01);
        repeat (SX + 2) tick();
        rd(2'd0, 8'h00, "held_no_edge");
        check("held_irq", {7'b0, O_interrupt}, 8'h00);

        // Edge pulse on source 0
        I_irq = 8'h00;
        repeat (SX + 1) tick();
        wr(2'd1, 8'h01);
        I_irq = 8'h01;
        tick();
        I_irq = 8'h00;
        repeat (SX) tick();
        check("edge_irq_pre", {7'b0, O_interrupt}, 8'h00);
        tick();
        check("edge_irq_post", {7'b0, O_interrupt}, 8'h01);
        rd(2'd0, 8'h01, "edge_pending");
        rd(2'd3, 8'h80, "edge_id");
        wr(2'd0, 8'h01);
        check("w1c_irq", {7'b0, O_interrupt}, 8'h00);
        rd(2'd0, 8'h00, "w1c_pending");

        // Level source 2
        wr(2'd2, 8'h00);
        wr(2'd1, 8'h04);
        I_irq = 8'h04;
        repeat (SX + 1) tick();
        rd(2'd0, 8'h04, "lvl_pending");
        rd(2'd3, 8'h82, "lvl_id");
        wr(2'd0, 8'h04);
        rd(2'd0, 8'h04, "lvl_w1c_ignored");
        check("lvl_irq", {7'b0, O_interrupt}, 8'h01);
        I_irq = 8'h00;
        repeat (SX) tick();
        tick();
        check("lvl_drop_irq_hold", {7'b0, O_interrupt}, 8'h01);
        tick();
        check("lvl_drop_irq", {7'b0, O_interrupt}, 8'h00);
        rd(2'd0, 8'h00, "lvl_drop_pending");

        // Masked edges latch, unmasking raises the request
        wr(2'd2, 8'hFF);
        wr(2'd1, 8'h00);
        I_irq = 8'h28;
        tick();
        I_irq = 8'h00;
        repeat (SX + 1) tick();
        rd(2'd0, 8'h28, "mask_pending");
        check("mask_irq", {7'b0, O_interrupt}, 8'h00);
        rd(2'd3, 8'h00, "mask_id");
        wr(2'd3, 8'hFF);
        wr(2'd1, 8'h20);
        check("unmask_irq", {7'b0, O_interrupt}, 8'h01);
        rd(2'd3, 8'h85, "unmask_id");
        rd(2'd2, 8'hFF, "mode_readback");

        // Edge in the same cycle as W1C: set wins
        wr(2'd0, 8'h28);
        rd(2'd0, 8'h00, "clear_all");
        I_irq = 8'h02;
        tick();
        I_irq = 8'h00;
        repeat (SX + 1) tick();
        rd(2'd0, 8'h02, "bit1_pending");
        I_irq = 8'h02;
        repeat (SX) tick();
        wr(2'd0, 8'h02);
        I_irq = 8'h00;
        rd(2'd0, 8'h02, "set_wins");

        // Level-to-edge switch clears a held level bit
        I_irq = 8'h40;
        wr(2'd2, 8'h00);
        repeat (SX + 1) tick();
        rd(2'd0, 8'h40, "lvl6_pending");
        wr(2'd2, 8'h40);
        rd(2'd0, 8'h00, "lvl_to_edge_clear");
        I_irq = 8'h00;
        tick();

        // Back-to-back strobes
        begin
            exp_t e;
            e.rd = 1'b1; e.exp = 8'h20; e.name = "b2b_rd0"; sb.push_back(e);
            e.name = "b2b_rd1"; sb.push_back(e);
        end
        STB_I = 1'b1;
        WE_I  = 1'b0;
        ADR_I = 2'd1;
        check("b2b_ack0", {7'b0, ACK_O}, 8'h00);
        tick();
        check("b2b_ack1", {7'b0, ACK_O}, 8'h01);
        tick();
        check("b2b_ack2", {7'b0, ACK_O}, 8'h00);
        tick();
        check("b2b_ack3", {7'b0, ACK_O}, 8'h01);
        tick();
        STB_I = 1'b0;
        tick();

        // Latency of an edge on source 7
        wr(2'd2, 8'h80);
        wr(2'd1, 8'h80);
        I_irq = 8'h80;
        n = 0;
        while (n < 12) begin
            tick();
            n++;
            if (n == 1)
                I_irq = 8'h00;
            if (O_interrupt === 1'b1)
                break;
        end
        check("irq_latency", 8'(n), 8'(2 + SX));

        // Reset in the middle of a read
        STB_I = 1'b1;
        WE_I  = 1'b0;
        ADR_I = 2'd3;
        tick();
        check("rst_mid_ack_before", {7'b0, ACK_O}, 8'h01);
        RST_I = 1'b1;
        #1;
        check("rst_mid_ack", {7'b0, ACK_O}, 8'h00);
        check("rst_mid_irq", {7'b0, O_interrupt}, 8'h00);
        STB_I = 1'b0;
        tick();
        RST_I = 1'b0;
        tick();
        rd(2'd1, 8'h00, "post_rst_enable");
        check("post_rst_irq", {7'b0, O_interrupt}, 8'h00);

        check("scoreboard_empty", 8'(sb.size()), 8'h00);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_ctrl_wb8.md
Name: irq_ctrl_wb8

Overview:
- 8-bit Wishbone slave interrupt controller that sits directly upstream of the CPU's INTERRUPT_I input.
- Aggregates up to 8 interrupt sources (timer, UART, SPI, buttons) into a single registered request line.
- Each source is individually configurable for rising-edge or level sensitivity and can be masked.
- Provides pending, enable and mode registers, plus a priority ID register for fast dispatch in the trap handler.

Parameters:
- NUM_IRQ, 8, number of implemented sources (1..8); unimplemented register bits read 0 and ignore writes.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  reset; asynchronous, active-high.
- ADR_I  in  2  register select.
- DAT_I  in  8  write data.
- DAT_O  out  8  read data, registered.
- STB_I  in  1  Wishbone strobe from the bus arbiter.
- WE_I  in  1  write enable.
- ACK_O  out  1  Wishbone acknowledge, registered.
- I_irq  in  NUM_IRQ  raw interrupt sources, active-high.
- O_interrupt  out  1  request to the CPU, registered.

Behaviour:
- Reset is asynchronous and active-high. It clears PENDING, ENABLE, MODE, DAT_O, ACK_O and O_interrupt to 0, and sets the edge-history register prev to all ones, so a source already high at reset release generates no edge.
- Register map (ADR_I):
  - 0 PENDING: read returns pending bits; writing 1 clears that edge-mode bit; writing 0 has no effect.
  - 1 ENABLE: read/write mask.
  - 2 MODE: read/write; bit=1 selects rising-edge, bit=0 selects level.
  - 3 ID: read-only. Bit7 = valid (any pending & enabled), bits[2:0] = lowest-numbered pending & enabled source, bits[6:3] = 0. When nothing is pending & enabled the register reads 0x00. Writes are acked and ignored.
- Handshake: ACK_O <= STB_I & !ACK_O every cycle, so each access is acked exactly one cycle after STB_I and back-to-back strobes ack every other cycle.
  - A write takes effect at the same edge ACK_O rises.
  - DAT_O is loaded at that same edge with the register value as it stood before the edge.
- Edge-mode sources:
  - Rising edge is detected as cur & !prev, where cur is the synchronized I_irq per the optional feature. prev <= cur every cycle.
  - A detected edge sets the pending bit.
  - If an edge and a W1C on the same bit occur in the same cycle, set wins.
  - The bit stays set until cleared, irrespective of ENABLE; masked sources still latch.
- Level-mode sources: pending bit <= cur every cycle; W1C has no effect.
- MODE writes:
  - Switching a bit from level to edge clears that pending bit at the write edge. An edge detected in the same cycle still sets it.
  - Switching edge to level lets the pending bit follow cur from the next cycle.
- O_interrupt <= |(PENDING & ENABLE), one cycle after the pending update.
  - Latency from an I_irq rising edge to O_interrupt = 2 cycles without sync, 4 cycles with sync.
  - An ENABLE write affects O_interrupt one cycle after the write edge.
- Reset asserted mid-transfer drops ACK_O immediately; the access is lost and the master must retry.

Optional Feature:
- Macro IRQ_CTRL_SYNC_EN.
- Defined: each I_irq bit passes through a 2-flop synchronizer (reset to 0) before edge/level logic, for asynchronous pins such as buttons. Adds 2 cycles of latency.
- Undefined: cur = I_irq directly; all sources must be synchronous to CLK_I.

Test Plan (all without IRQ_CTRL_SYNC_EN unless stated):
- Reset with I_irq=0x01 held -> all registers read 0x00, O_interrupt=0; with MODE=0x01 written after reset and I_irq=0x01 still held, no pending is set.
- MODE=0x01, ENABLE=0x01, pulse I_irq[0] 1 cycle -> PENDING=0x01, O_interrupt=1 two cycles after the pulse, ID=0x80. Write PENDING 0x01 -> PENDING=0x00, O_interrupt=0 one cycle later.
- MODE=0x00, ENABLE=0x04, I_irq[2] held high -> PENDING=0x04, ID=0x82; W1C 0x04 -> still 0x04; drop I_irq[2] -> PENDING=0x00 next cycle, O_interrupt=0 the cycle after.
- MODE=0xFF, ENABLE=0x00, edges on bits 5 and 3 -> PENDING=0x28, O_interrupt=0, ID=0x00; write ENABLE=0x20 -> O_interrupt=1, ID=0x85.
- Edge on bit 1 in the same cycle as a W1C of 0x02 -> PENDING bit 1 remains 1. Back-to-back STB_I held 4 cycles -> ACK_O pattern 0,1,0,1.
- With IRQ_CTRL_SYNC_EN: edge-mode pulse on I_irq[7] -> O_interrupt rises exactly 4 cycles after the pulse; assert RST_I mid-read -> ACK_O and O_interrupt drop in the same cycle.
